// File: rtl/mem_access_unit.sv
// Load/store front end: computes base+offset, sequences one data-memory access
// with a fixed read latency and returns data/completion or a range error.
module mem_access_unit #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [ADDR_W-1:0] req_offset,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] address_bus,
   output logic [DATA_W-1:0] data_in,
   output logic              r_w,
   input  logic [DATA_W-1:0] data_out
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] din_d;
   logic              rw_d;
   logic              rv_d;
   logic [DATA_W-1:0] rd_d;
   logic              err_d;

   // One extra bit catches both underflow and overflow: any result outside
   // 0..2^ADDR_W-1 lands with the top bit set.
   logic [ADDR_W:0]   ea_sum;
   logic              ea_err;

   assign ea_sum    = {1'b0, req_base} + {req_offset[ADDR_W-1], req_offset};
   assign ea_err    = ea_sum[ADDR_W];
   assign req_ready = (state_q == IDLE);

   // Next-state and next-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = address_bus;
      din_d   = data_in;
      rw_d    = 1'b0;
      rv_d    = resp_valid;
      rd_d    = resp_rdata;
      err_d   = resp_err;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d = req_we;
               if (ea_err) begin
                  state_d = RESP;
                  rv_d    = 1'b1;
                  err_d   = 1'b1;
                  rd_d    = {DATA_W{1'b0}};
               end else begin
                  state_d = ACCESS;
                  addr_d  = ea_sum[ADDR_W-1:0];
                  din_d   = req_wdata;
                  rw_d    = req_we;
                  cnt_d   = CNT_W'(MEM_LAT);
               end
            end
         end
         ACCESS: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               rv_d    = 1'b1;
               err_d   = 1'b0;
               rd_d    = we_q ? {DATA_W{1'b0}} : data_out;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
               rv_d    = 1'b0;
               err_d   = 1'b0;
               rd_d    = {DATA_W{1'b0}};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; async reset also kills a pending write strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         we_q        <= 1'b0;
         address_bus <= {ADDR_W{1'b0}};
         data_in     <= {DATA_W{1'b0}};
         r_w         <= 1'b0;
         resp_valid  <= 1'b0;
         resp_rdata  <= {DATA_W{1'b0}};
         resp_err    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         address_bus <= addr_d;
         data_in     <= din_d;
         r_w         <= rw_d;
         resp_valid  <= rv_d;
         resp_rdata  <= rd_d;
         resp_err    <= err_d;
      end
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end that sits directly upstream of the data memory and drives its `address_bus`, `data_in` and `r_w` inputs while consuming its `data_out`. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and computes the effective address as base plus signed offset. It sequences the memory access with a configurable read latency and returns the load data, or a completion for stores, over a second valid/ready handshake. Out-of-range addresses are rejected with an error response, and the memory is never touched for them.

## Interface
- `ADDR_W`, 8: width of base, offset and memory address.
- `DATA_W`, 8: memory data width.
- `MEM_LAT`, 1: cycles from stable address to valid `data_out` (≥1).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; equals (state == IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_base`  in  ADDR_W  unsigned base address.
- `req_offset`  in  ADDR_W  two's-complement offset.
- `req_wdata`  in  DATA_W  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  DATA_W  load data; 0 for stores and errors.
- `resp_err`  out  1  effective address out of range.
- `address_bus`  out  ADDR_W  to data memory.
- `data_in`  out  DATA_W  to data memory.
- `r_w`  out  1  to data memory; 1 = write, 0 = read.
- `data_out`  in  DATA_W  from data memory.

## Operation
- States:
  - IDLE → ACCESS when a request is accepted with no error.
  - IDLE → RESP when a request is accepted with an error.
  - ACCESS → RESP after MEM_LAT cycles.
  - RESP → IDLE when `resp_ready` is 1.
- Accept: a request is accepted on an edge where `req_valid && req_ready`. On that edge:
  - `req_we` and `req_wdata` are latched.
  - The effective address is latched into `address_bus`.
- Effective address:
  - Computed as the ADDR_W+1-bit sum {0,base} + sext(offset).
  - Error when the sum is < 0 or > 2^ADDR_W−1; for example, base 0xFF with offset +1, or base 0x00 with offset −1.
  - No wrap-around.
- ACCESS:
  - `address_bus` and `data_in` are held stable for all MEM_LAT cycles.
  - Store: `r_w` = 1 in the first ACCESS cycle only, and 0 otherwise.
  - Load: `r_w` = 0 throughout; `data_out` is captured into `resp_rdata` on the edge that ends the last ACCESS cycle.
  - An internal down-counter of width clog2(MEM_LAT+1) is loaded with MEM_LAT at accept.
- RESP:
  - `resp_valid` = 1; `resp_rdata` and `resp_err` are held until the handshake completes.
  - A new request cannot be accepted until the state returns to IDLE.
- Error path: `r_w` stays 0, `address_bus` and `data_in` are unchanged, and `resp_err` = 1 with `resp_rdata` = 0.
- Outside ACCESS: `r_w` = 0, and `address_bus`/`data_in` retain their last values.
- Reset values:
  - state IDLE, so `req_ready` = 1.
  - `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0.
  - `address_bus` = 0, `data_in` = 0, `r_w` = 0.
- Reset mid-operation: everything is cleared immediately, without waiting for a clock edge.
  - The in-flight request is dropped, with no response.
  - `r_w` drops to 0 combinationally with `rst_n`, so a partial store cannot complete after reset.

## Timing
- All outputs are registered except `req_ready`, which decodes state.
- Cycle 0: accept edge.
  - Load: cycles 1..MEM_LAT are ACCESS; `resp_valid` rises in cycle MEM_LAT+1. With MEM_LAT = 1, the response appears 2 cycles after accept.
  - Store: same as load; `r_w` is high only in cycle 1.
  - Error: `resp_valid` in cycle 1.
- Response handshake: when `resp_valid && resp_ready` at an edge, `resp_valid` drops the next cycle and `req_ready` rises.
- Maximum throughput: one request per MEM_LAT+2 cycles, with `resp_ready` tied high.
- If `req_valid` is asserted while not IDLE, it is ignored; the requester must hold it until `req_ready`.

## Test plan
- Store base 0x00 offset 0x00 data 0x01, then base 0x00 offset 0x01 data 0x07 → `r_w` = 1 for exactly one cycle each, at `address_bus` 0x00 then 0x01; two responses with `resp_err` = 0.
- Load 0x00 then 0x01 after those stores (behavioural memory) → `resp_rdata` 0x01 then 0x07, each arriving at cycle MEM_LAT+1 after accept; repeat with MEM_LAT = 3.
- Load base 0x10 offset 0xFF (−1) → `address_bus` 0x0F; store base 0x80 offset 0x7F → `address_bus` 0xFF with no error.
- Store base 0xFF offset 0x01, and load base 0x00 offset 0xFF → `resp_err` = 1, `resp_rdata` 0x00, `r_w` never 1, `address_bus` unchanged.
- Load with `resp_ready` held low 3 cycles → `resp_valid`/`resp_rdata` stable, `req_ready` = 0, and a second `req_valid` is not accepted until the cycle after the handshake.
- Pull `rst_n` low during the ACCESS cycle of a store → `r_w` falls immediately, no response is issued, all outputs take their reset values, and `req_ready` = 1 after release.
